// File: rtl/tlm_xmit_sched.sv
// Batch scheduler: loads NUM operand pairs into a register buffer, then streams
// them one pair per accepted beat, repeating for NUM_BATCH batches per run.
module tlm_xmit_sched #(
    parameter int NUM        = 50,
    parameter int ITEM_WIDTH = 8,
    parameter int NUM_BATCH  = 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    output logic                           batch_req_o,
    input  logic                           load_valid_i,
    input  logic [ITEM_WIDTH-1:0]          load_a_i,
    input  logic [ITEM_WIDTH-1:0]          load_b_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [ITEM_WIDTH-1:0]          a_o,
    output logic [ITEM_WIDTH-1:0]          b_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [$clog2(NUM_BATCH+1)-1:0] batch_cnt_o,
    output logic [$clog2(NUM+1)-1:0]       item_cnt_o,
    output logic [1:0]                     state_o
);

    localparam int IW = $clog2(NUM + 1);
    localparam int BW = $clog2(NUM_BATCH + 1);
    localparam int AW = (NUM > 1) ? $clog2(NUM) : 1;

    // Handshake: a pair transfers on every cycle where valid_o && ready_i;
    // once valid_o rises, a_o/b_o/valid_o stay stable until that beat.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   item_cnt, item_nxt;
    logic [BW-1:0]   batch_cnt, batch_nxt;
    logic [AW-1:0]   idx;
    logic            load_en;
    logic            beat;
    logic            last_item;

    logic [ITEM_WIDTH-1:0] mem_a [NUM];
    logic [ITEM_WIDTH-1:0] mem_b [NUM];

    assign idx       = item_cnt[AW-1:0];
    assign last_item = (item_cnt == IW'(NUM - 1));
    assign load_en   = (state == REQ) && load_valid_i && !abort_i;
    assign beat      = (state == XMIT) && ready_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            item_cnt  <= '0;
            batch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            item_cnt  <= item_nxt;
            batch_cnt <= batch_nxt;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk_i) begin
        if (load_en) begin
            mem_a[idx] <= load_a_i;
            mem_b[idx] <= load_b_i;
        end
    end

    always_comb begin
        state_nxt = state;
        item_nxt  = item_cnt;
        batch_nxt = batch_cnt;
        if (abort_i) begin
            state_nxt = IDLE;
            item_nxt  = '0;
            batch_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state_nxt = REQ;
                        item_nxt  = '0;
                        batch_nxt = '0;
                    end
                end
                REQ: begin
                    if (load_valid_i) begin
                        if (last_item) begin
                            item_nxt  = '0;
                            state_nxt = XMIT;
                        end else begin
                            item_nxt = item_cnt + 1'b1;
                        end
                    end
                end
                XMIT: begin
                    if (beat) begin
                        if (last_item) begin
                            item_nxt  = '0;
                            batch_nxt = batch_cnt + 1'b1;
                            state_nxt = (batch_cnt + 1'b1 == BW'(NUM_BATCH)) ? DONE : REQ;
                        end else begin
                            item_nxt = item_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operands read as zero whenever no pair is offered, matching bfm reset values.
    assign valid_o     = (state == XMIT);
    assign a_o         = valid_o ? mem_a[idx] : '0;
    assign b_o         = valid_o ? mem_b[idx] : '0;
    assign batch_req_o = (state == REQ);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign batch_cnt_o = batch_cnt;
    assign item_cnt_o  = item_cnt;
    assign state_o     = state;

endmodule

// File: doc/tlm_xmit_sched.md
Name: tlm_xmit_sched

Overview:
- Batch scheduler between the DPI payload loader and the `bfm` operand inputs.
- Requests a batch of NUM operand pairs, buffers it, then streams one pair per accepted beat over a valid/ready interface.
- Repeats for NUM_BATCH batches, then signals run completion.
- Replaces the free-running xmit_en toggle with an explicit handshake, so back-pressure and aborts are handled cycle-exactly.

Parameters:
- NUM, 50, operand pairs per batch (>=1).
- ITEM_WIDTH, 8, bits per operand.
- NUM_BATCH, 3, batches per run (>=1).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse that begins a run; honoured in IDLE only.
- abort_i  in  1  synchronous abort; returns to IDLE.
- batch_req_o  out  1  high while a batch load is requested (state REQ).
- load_valid_i  in  1  loader presents one pair this cycle.
- load_a_i  in  ITEM_WIDTH  operand A of the loaded pair.
- load_b_i  in  ITEM_WIDTH  operand B of the loaded pair.
- valid_o  out  1  a_o/b_o hold a valid pair (state XMIT).
- ready_i  in  1  downstream accepts the pair this cycle.
- a_o  out  ITEM_WIDTH  operand A to bfm A_s.
- b_o  out  ITEM_WIDTH  operand B to bfm B_s.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when the run completes.
- batch_cnt_o  out  $clog2(NUM_BATCH+1)  batches fully transmitted in the current run.
- item_cnt_o  out  $clog2(NUM+1)  pairs loaded (REQ) or transmitted (XMIT) in the current batch.

Behaviour:
- Reset (reset_i low, asynchronous): state=IDLE; all outputs 0; buffer contents don't-care; counters 0.
- Storage: 2 x NUM x ITEM_WIDTH register buffer, written only in REQ; wr_ptr/rd_ptr share the item counter.
- IDLE: outputs 0.
  - start_i=1 -> REQ next cycle; batch_cnt cleared.
  - start_i pulses while not in IDLE are ignored.
- REQ: batch_req_o=1.
  - Each cycle with load_valid_i=1 writes {load_a_i, load_b_i} to entry item_cnt and increments item_cnt.
  - When the NUM-th pair is accepted: item_cnt clears, state goes to XMIT next cycle.
  - load_valid_i outside REQ is ignored and causes no write.
- XMIT: valid_o=1; a_o/b_o = buffer[item_cnt], combinational from the registered buffer.
  - Beat = valid_o & ready_i; each beat increments item_cnt.
  - While ready_i=0, a_o/b_o/valid_o hold stable.
  - On the NUM-th beat: item_cnt clears and batch_cnt increments.
    - If the new batch_cnt == NUM_BATCH -> DONE.
    - Otherwise -> REQ.
- DONE: done_o=1 for exactly one cycle, busy_o=1, then IDLE. batch_cnt_o holds NUM_BATCH until the next start.
- When valid_o=0, a_o/b_o = 0, matching the bfm reset operands.
- Latency:
  - First valid_o is the cycle after the NUM-th load is accepted.
  - With ready_i held high, one batch transmits in exactly NUM cycles.
  - REQ is re-entered the cycle after the last beat.
- abort_i=1 in any state:
  - Priority over start_i, loads and beats in the same cycle.
  - Next state IDLE; counters cleared; no done_o pulse; an in-flight beat in that cycle is still counted downstream but discarded internally.
- ready_i while valid_o=0 has no effect.
- Reset asserted mid-run: immediate return to IDLE, outputs 0.

Test Plan:
- Nominal run, NUM=4, NUM_BATCH=2, ready_i=1, load_valid_i=1 continuously, pairs (1,2),(3,4),(5,6),(7,8):
  - batch_req_o high 4 cycles, then valid_o high 4 cycles with a_o/b_o = 1/2, 3/4, 5/6, 7/8.
  - Sequence repeats once more, then done_o pulses once.
  - batch_cnt_o=2; busy_o low the cycle after done_o.
- Back-pressure: ready_i=0 for 3 cycles on the second beat:
  - a_o=3, b_o=4 stay stable with valid_o=1 throughout.
  - Transfer completes in NUM+3 cycles.
- Gapped loads: load_valid_i toggling 1/0:
  - item_cnt_o increments only on high cycles.
  - XMIT entered exactly one cycle after the 4th accepted load.
- Abort during XMIT after 2 beats:
  - Next cycle state IDLE; valid_o=0, a_o=b_o=0, item_cnt_o=0, batch_cnt_o=0, no done_o.
  - A subsequent start_i starts cleanly with batch_req_o=1.
- Ignored inputs:
  - start_i pulsed in XMIT, load_valid_i pulsed in XMIT and IDLE: no state or counter change, no buffer write (verify by unchanged a_o sequence).
- Async reset mid-REQ:
  - reset_i low between clock edges: all outputs 0 immediately.
  - After release, IDLE until start_i.
